mem_access: RTL
===============

Name: mem_access

Overview:
- MEM-stage data-memory access unit of the RV32I pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB register.
- Drives a req/gnt/rvalid data-memory bus for loads and stores, and aligns, sign- or zero-extends load data.
- Raises a stall to hold upstream stages while a memory transaction is outstanding.

Parameters:
ADDR_W, 32, data-memory byte-address width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
valid_i  in  1  instruction present in MEM stage
mem_read_i  in  1  load
mem_write_i  in  1  store
funct3_i  in  3  load/store size and signedness (RV32I encoding)
alu_result_i  in  32  effective address, or ALU result for non-memory ops
store_data_i  in  32  rs2 value
rd_addr_i  in  5  destination register
rd_wen_i  in  1  register write enable
dmem_req_o  out  1  bus request
dmem_we_o  out  1  1 = store
dmem_addr_o  out  ADDR_W  word-aligned address (bits [1:0] = 0)
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  32  lane-replicated store data
dmem_gnt_i  in  1  request accepted this cycle
dmem_rvalid_i  in  1  load data valid
dmem_rdata_i  in  32  load data word
rd_addr_o  out  5  to MEM/WB
rd_data_o  out  32  to MEM/WB
rd_wen_o  out  1  to MEM/WB
stall_o  out  1  hold PC, IF/ID, ID/EX, EX/MEM
mem_err_o  out  1  misaligned access or illegal funct3; one-cycle pulse

Behaviour:
- FSM states: IDLE, REQ (request issued, no gnt yet), WAIT (load granted, awaiting rvalid).
- On any memory op in IDLE, latch addr[1:0], funct3, rd_addr, address/be/wdata.
- IDLE, non-memory op: pass-through, combinational. rd_data_o = alu_result_i, rd_wen_o = valid_i & rd_wen_i. No stall.
- IDLE, legal aligned memory op: dmem_req_o = 1 in the same cycle.
  - gnt same cycle, store: done, no stall, rd_wen_o = 0.
  - gnt same cycle, load: go to WAIT, stall_o = 1.
  - no gnt: go to REQ, stall_o = 1.
- REQ: dmem_req_o held at 1; addr/we/be/wdata stable from latches until gnt. stall_o = 1, rd_wen_o = 0.
  - On gnt, store: go to IDLE, stall_o = 0 that cycle.
  - On gnt, load: go to WAIT, stall_o stays 1.
- WAIT: dmem_req_o = 0.
  - Without rvalid: stall_o = 1, rd_wen_o = 0.
  - With rvalid: rd_data_o = formatted rdata, rd_addr_o = latched rd, rd_wen_o = latched wen; stall_o = 0; go to IDLE.
- rvalid is legal no earlier than the cycle after gnt. rvalid in IDLE or REQ is ignored.
- While stall_o = 1, rd_wen_o = 0, so MEM/WB captures a bubble every stalled cycle.
- Minimum latencies:
  - Store with immediate gnt: 0 stall cycles.
  - Load with immediate gnt and rvalid next cycle: 1 stall cycle.
- Load formatting (offset = addr[1:0]):
  - LB/LBU: byte at offset, sign-/zero-extended.
  - LH/LHU: half at addr[1], sign-/zero-extended.
  - LW: whole word.
- Store formatting:
  - SB: be = 0001 << offset; wdata = byte replicated ×4.
  - SH: be = 0011 (addr[1]=0) or 1100; wdata = half replicated ×2.
  - SW: be = 1111; wdata = word.
- Error conditions: halfword with addr[0] = 1, word with addr[1:0] ≠ 0, load funct3 ∈ {3,6,7}, store funct3 ≥ 3.
  - Response: no request issued, mem_err_o = 1 for that cycle, rd_wen_o = 0, no stall.
- mem_read_i and mem_write_i both high is treated as illegal: mem_err_o = 1.
- Reset (async, any state):
  - FSM to IDLE, latches cleared.
  - dmem_req_o = 0, stall_o = 0, rd_wen_o = 0, rd_addr_o = 0, rd_data_o = 0, mem_err_o = 0.
  - An outstanding transaction is abandoned; its late rvalid is ignored.
- valid_i = 0 in IDLE: no request, rd_wen_o = 0.

Decomposition:
- Shared package holds:
  - funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW;
  - FSM state encoding (IDLE/REQ/WAIT, 2 bits).
- One combinational sub-module, mem_align, implements the load extract/extend and the store be/wdata replicate. Instantiate it for the issue path and the load-return path.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt same cycle → req 1 cycle, be=1111, addr=0x100, stall_o never 1, rd_wen_o=0.
- LB addr 0x203, gnt same cycle, rvalid next cycle with rdata 0x80FF_0000 → stall_o=1 for 1 cycle, then rd_data_o=0xFFFFFF80, rd_wen_o=1.
- SH addr 0x32 data 0x1234, gnt delayed 3 cycles → req/addr=0x30/be=1100/wdata=0x12341234 held stable for 4 cycles, stall_o=1 for 3 cycles.
- LW addr 0x102 → mem_err_o=1 for one cycle, dmem_req_o=0, rd_wen_o=0; same for load funct3=3.
- ADD result 0x55 with rd=x5 → rd_data_o=0x55, rd_addr_o=5, rd_wen_o=1 same cycle.
- LHU in WAIT, rst low for 1 cycle, then stray rvalid → state IDLE, rd_wen_o stays 0, stall_o=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared funct3 encodings, FSM states and access legality rule for the MEM stage
package mem_access_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Legal funct3 for the direction, and natural alignment for halfwords and words
    function automatic logic access_ok(input logic store, input logic [2:0] f3, input logic [1:0] off);
        return (store ? (f3 == F3_SB || f3 == F3_SH || f3 == F3_SW)
                      : (f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU))
            && !(f3[1:0] == 2'b01 && off[0])
            && !(f3[1:0] == 2'b10 && off != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// mem_align: load byte/half extract with sign/zero extension, and store byte-enable/lane replication
module mem_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] sdata,
    output logic [31:0] load_data,
    output logic [3:0]  be,
    output logic [31:0] wdata
);

    logic [7:0]  b;
    logic [15:0] h;

    // funct3[1:0] selects size, funct3[2] selects zero extension on loads
    always_comb begin
        b         = rdata[{offset, 3'b000} +: 8];
        h         = offset[1] ? rdata[31:16] : rdata[15:0];
        load_data = (funct3[1:0] == 2'b00) ? {{24{~funct3[2] & b[7]}}, b}
                  : (funct3[1:0] == 2'b01) ? {{16{~funct3[2] & h[15]}}, h}
                  : rdata;
        be        = (funct3[1:0] == 2'b00) ? 4'b0001 << offset
                  : (funct3[1:0] == 2'b01) ? (offset[1] ? 4'b1100 : 4'b0011)
                  : 4'b1111;
        wdata     = (funct3[1:0] == 2'b00) ? {4{sdata[7:0]}}
                  : (funct3[1:0] == 2'b01) ? {2{sdata[15:0]}}
                  : sdata;
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit driving a req/gnt/rvalid data bus and stalling upstream
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        funct3_i,
    input  logic [31:0]       alu_result_i,
    input  logic [31:0]       store_data_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              rd_wen_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [31:0]       dmem_rdata_i,
    output logic [4:0]        rd_addr_o,
    output logic [31:0]       rd_data_o,
    output logic              rd_wen_o,
    output logic              stall_o,
    output logic              mem_err_o
);

    state_t            state, nxt;
    logic              mem_op, legal, issue, idle_st, req_st, wait_st;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q, be_i, unused_be;
    logic [31:0]       wdata_q, wdata_i, load_data, unused_load, unused_wdata;
    logic              we_q, wen_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [4:0]        rd_q;

    mem_align u_issue (
        .funct3    (funct3_i),
        .offset    (alu_result_i[1:0]),
        .rdata     (32'h0),
        .sdata     (store_data_i),
        .load_data (unused_load),
        .be        (be_i),
        .wdata     (wdata_i)
    );

    mem_align u_return (
        .funct3    (f3_q),
        .offset    (off_q),
        .rdata     (dmem_rdata_i),
        .sdata     (32'h0),
        .load_data (load_data),
        .be        (unused_be),
        .wdata     (unused_wdata)
    );

    // Next state, bus drive and MEM/WB outputs; reset forces every result output quiet
    always_comb begin
        idle_st      = state == IDLE;
        req_st       = state == REQ;
        wait_st      = state == WAIT;
        mem_op       = valid_i & (mem_read_i | mem_write_i);
        legal        = mem_op & ~(mem_read_i & mem_write_i) & access_ok(mem_write_i, funct3_i, alu_result_i[1:0]);
        issue        = idle_st & legal;
        nxt          = issue   ? (dmem_gnt_i ? (mem_write_i ? IDLE : WAIT) : REQ)
                     : req_st  ? (dmem_gnt_i ? (we_q ? IDLE : WAIT) : REQ)
                     : wait_st ? (dmem_rvalid_i ? IDLE : WAIT)
                     : IDLE;
        dmem_req_o   = issue | req_st;
        dmem_we_o    = req_st ? we_q : issue & mem_write_i;
        dmem_addr_o  = req_st ? addr_q : issue ? {alu_result_i[ADDR_W-1:2], 2'b00} : '0;
        dmem_be_o    = req_st ? be_q : issue ? be_i : 4'h0;
        dmem_wdata_o = req_st ? wdata_q : issue ? wdata_i : 32'h0;
        stall_o      = (issue & ~(dmem_gnt_i & mem_write_i)) | (req_st & ~(dmem_gnt_i & we_q)) | (wait_st & ~dmem_rvalid_i);
        mem_err_o    = idle_st & mem_op & ~legal;
        rd_addr_o    = idle_st ? rd_addr_i : rd_q;
        rd_data_o    = wait_st ? load_data : idle_st ? alu_result_i : 32'h0;
        rd_wen_o     = idle_st ? valid_i & rd_wen_i & ~mem_op : wait_st & dmem_rvalid_i & wen_q;
        if (!rst) begin
            dmem_req_o   = 1'b0;
            dmem_we_o    = 1'b0;
            dmem_addr_o  = '0;
            dmem_be_o    = 4'h0;
            dmem_wdata_o = 32'h0;
            stall_o      = 1'b0;
            mem_err_o    = 1'b0;
            rd_addr_o    = 5'd0;
            rd_data_o    = 32'h0;
            rd_wen_o     = 1'b0;
        end
    end

    // State register, and capture of the transaction so it stays stable while the bus stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            rd_q    <= 5'd0;
            wen_q   <= 1'b0;
        end else begin
            state <= nxt;
            if (idle_st && mem_op) begin
                addr_q  <= {alu_result_i[ADDR_W-1:2], 2'b00};
                be_q    <= be_i;
                wdata_q <= wdata_i;
                we_q    <= mem_write_i;
                f3_q    <= funct3_i;
                off_q   <= alu_result_i[1:0];
                rd_q    <= rd_addr_i;
                wen_q   <= rd_wen_i;
            end
        end
    end

endmodule
